// File: rtl/id_scanner.sv
// rtl/id_scanner.sv - byte-serial letter+ digit+ identifier scanner with length and count tracking
//
// Purpose:
//   Classifies each sampled character as letter (L), digit (D) or delimiter (X)
//   and tracks whether the current token has the form L+ D+ and fits in MAX_LEN
//   characters. Completed identifiers, meaning a delimiter that ends a legal
//   token, are counted, and their length is latched.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   reset     in   1      synchronous active-high reset
//   valid     in   1      char is sampled on this edge only when 1
//   char      in   8      ASCII character
//   out       out  1      current token is a legal identifier (DIGIT state)
//   err       out  1      current token is illegal (FAIL state)
//   len       out  LEN_W  characters in current token, saturating at all-ones
//   last_len  out  LEN_W  length of the most recently completed identifier
//   id_count  out  CNT_W  completed identifiers, wraps modulo 2^CNT_W

module id_scanner #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 8,
    parameter int ALLOW_US = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [7:0]       char,
    output logic             out,
    output logic             err,
    output logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] last_len,
    output logic [CNT_W-1:0] id_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALPHA = 2'd1,
        S_DIGIT = 2'd2,
        S_FAIL  = 2'd3
    } state_e;

    // One extra bit so the incremented length can exceed MAX_LEN and the
    // all-ones saturation point without wrapping before the comparison.
    localparam logic [LEN_W:0]   MAX_LEN_V = (LEN_W+1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = {LEN_W{1'b1}};

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] last_len_q, last_len_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             is_letter;
    logic             is_digit;
    logic [LEN_W:0]   nl;

    // Character classification
    always_comb begin
        is_letter = 1'b0;
        is_digit  = 1'b0;
        if ((char >= 8'h61) && (char <= 8'h7A)) begin
            is_letter = 1'b1;
        end
        if ((char >= 8'h41) && (char <= 8'h5A)) begin
            is_letter = 1'b1;
        end
        if ((ALLOW_US != 0) && (char == 8'h5F)) begin
            is_letter = 1'b1;
        end
        if ((char >= 8'h30) && (char <= 8'h39)) begin
            is_digit = 1'b1;
        end
    end

    assign nl = {1'b0, len_q} + (LEN_W+1)'(1);

    // Next-state, length and completion logic
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        last_len_d = last_len_q;
        count_d    = count_q;

        if (valid) begin
            if (is_letter || is_digit) begin
                case (state_q)
                    S_IDLE:  state_d = is_letter ? S_ALPHA : S_FAIL;
                    S_ALPHA: state_d = is_letter ? S_ALPHA : S_DIGIT;
                    S_DIGIT: state_d = is_letter ? S_FAIL  : S_DIGIT;
                    default: state_d = S_FAIL;
                endcase

                // Over-length tokens fail regardless of their shape.
                if (nl > MAX_LEN_V) begin
                    state_d = S_FAIL;
                end

                // Keep counting inside FAIL, but hold at all-ones.
                len_d = (len_q == LEN_SAT) ? LEN_SAT : nl[LEN_W-1:0];
            end else begin
                state_d = S_IDLE;
                len_d   = '0;
                if (state_q == S_DIGIT) begin
                    count_d    = count_q + CNT_W'(1);
                    last_len_d = len_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            last_len_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            last_len_q <= last_len_d;
            count_q    <= count_d;
        end
    end

    assign out      = (state_q == S_DIGIT);
    assign err      = (state_q == S_FAIL);
    assign len      = len_q;
    assign last_len = last_len_q;
    assign id_count = count_q;

endmodule

// File: tb/tb_id_scanner.sv
// tb/tb_id_scanner.sv - directed self-checking bench for id_scanner

module tb_id_scanner;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [7:0] char;

    int n_checks;
    int n_fail;

    // MAX_LEN=8, ALLOW_US=0
    logic       out8, err8;
    logic [3:0] len8, last8;
    logic [7:0] cnt8;
    // MAX_LEN=16, LEN_W=5
    logic       out16, err16;
    logic [4:0] len16, last16;
    logic [7:0] cnt16;
    // ALLOW_US=1
    logic       outu, erru;
    logic [3:0] lenu, lastu;
    logic [7:0] cntu;
    // CNT_W=2
    logic       outc, errc;
    logic [3:0] lenc, lastc;
    logic [1:0] cntc;

    id_scanner #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .ALLOW_US(0)) u_m8 (
        .clk(clk), .reset(reset), .valid(valid), .char(char),
        .out(out8), .err(err8), .len(len8), .last_len(last8), .id_count(cnt8)
    );

    id_scanner #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .ALLOW_US(0)) u_m16 (
        .clk(clk), .reset(reset), .valid(valid), .char(char),
        .out(out16), .err(err16), .len(len16), .last_len(last16), .id_count(cnt16)
    );

    id_scanner #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .ALLOW_US(1)) u_us (
        .clk(clk), .reset(reset), .valid(valid), .char(char),
        .out(outu), .err(erru), .len(lenu), .last_len(lastu), .id_count(cntu)
    );

    id_scanner #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2), .ALLOW_US(0)) u_c2 (
        .clk(clk), .reset(reset), .valid(valid), .char(char),
        .out(outc), .err(errc), .len(lenc), .last_len(lastc), .id_count(cntc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one character, wait for the sampling edge, settle 1 time unit.
    task automatic step(input logic [7:0] c, input logic v);
        valid = v;
        char  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(8'h00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        valid = 1'b1;
        char  = "a";
        do_reset();
        n_checks++;
        if ({out8, err8, len8, last8, cnt8} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_m8 got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     out8, err8, len8, last8, cnt8);
        end
        n_checks++;
        if ({out16, err16, len16, last16, cnt16} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_m16 got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     out16, err16, len16, last16, cnt16);
        end
        n_checks++;
        if ({outc, errc, lenc, lastc, cntc} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_c2 got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     outc, errc, lenc, lastc, cntc);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] s [8];
        s = '{"a", "b", "c", "d", "1", "2", "3", "4"};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(s[i], 1'b1);
            n_checks++;
            if ({out8, err8, len8} !== {(i >= 4) ? 1'b1 : 1'b0, 1'b0, 4'(i + 1)}) begin
                n_fail++;
                $display("FAIL max_len_char%0d got out=%0b err=%0b len=%0d want out=%0b err=0 len=%0d",
                         i, out8, err8, len8, (i >= 4), i + 1);
            end
        end
        step("1", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b0, 1'b1, 4'd9}) begin
            n_fail++;
            $display("FAIL max_len_over8 got out=%0b err=%0b len=%0d want out=0 err=1 len=9",
                     out8, err8, len8);
        end
        n_checks++;
        if ({out16, err16, len16} !== {1'b1, 1'b0, 5'd9}) begin
            n_fail++;
            $display("FAIL max_len_ok16 got out=%0b err=%0b len=%0d want out=1 err=0 len=9",
                     out16, err16, len16);
        end
        step("/", 1'b1);
        n_checks++;
        if ({out8, err8, len8, last8, cnt8} !== 18'd0) begin
            n_fail++;
            $display("FAIL max_len_end8 got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     out8, err8, len8, last8, cnt8);
        end
        n_checks++;
        if ({out16, err16, len16, last16, cnt16} !== {1'b0, 1'b0, 5'd0, 5'd9, 8'd1}) begin
            n_fail++;
            $display("FAIL max_len_end16 got out=%0b err=%0b len=%0d last=%0d cnt=%0d want 0 0 0 9 1",
                     out16, err16, len16, last16, cnt16);
        end
    endtask

    task automatic test_fail_path();
        do_reset();
        step("1", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL leading_digit got out=%0b err=%0b len=%0d want 0 1 1", out8, err8, len8);
        end
        step("a", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b0, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL fail_sticky got out=%0b err=%0b len=%0d want 0 1 2", out8, err8, len8);
        end
        step("/", 1'b1);
        n_checks++;
        if ({out8, err8, len8, last8, cnt8} !== 18'd0) begin
            n_fail++;
            $display("FAIL fail_exit got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     out8, err8, len8, last8, cnt8);
        end
        step("x", 1'b1);
        step("9", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b1, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL x9_legal got out=%0b err=%0b len=%0d want 1 0 2", out8, err8, len8);
        end
        step("a", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b0, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL letter_after_digit got out=%0b err=%0b len=%0d want 0 1 3", out8, err8, len8);
        end
    endtask

    task automatic test_underscore();
        do_reset();
        step("_", 1'b1);
        n_checks++;
        if ({len8, lenu} !== {4'd0, 4'd1}) begin
            n_fail++;
            $display("FAIL us_class got len_us0=%0d len_us1=%0d want 0 1", len8, lenu);
        end
        step("a", 1'b1);
        step("1", 1'b1);
        step(" ", 1'b1);
        n_checks++;
        if ({cnt8, last8} !== {8'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL us_off got cnt=%0d last=%0d want 1 2", cnt8, last8);
        end
        n_checks++;
        if ({cntu, lastu} !== {8'd1, 4'd3}) begin
            n_fail++;
            $display("FAIL us_on got cnt=%0d last=%0d want 1 3", cntu, lastu);
        end
    endtask

    task automatic test_valid_hold();
        do_reset();
        step("a", 1'b1);
        step("b", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("9", 1'b0);
            n_checks++;
            if ({out8, err8, len8, cnt8} !== {1'b0, 1'b0, 4'd2, 8'd0}) begin
                n_fail++;
                $display("FAIL valid_hold%0d got out=%0b err=%0b len=%0d cnt=%0d want 0 0 2 0",
                         i, out8, err8, len8, cnt8);
            end
        end
        step("1", 1'b1);
        n_checks++;
        if ({out8, err8, len8} !== {1'b1, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL valid_resume got out=%0b err=%0b len=%0d want 1 0 3", out8, err8, len8);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step("a", 1'b1);
        step("b", 1'b1);
        step("1", 1'b1);
        step("2", 1'b1);
        n_checks++;
        if ({out8, len8} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL pre_reset got out=%0b len=%0d want 1 4", out8, len8);
        end
        reset = 1'b1;
        step("/", 1'b1);
        reset = 1'b0;
        n_checks++;
        if ({out8, err8, len8, last8, cnt8} !== 18'd0) begin
            n_fail++;
            $display("FAIL mid_reset got out=%0b err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     out8, err8, len8, last8, cnt8);
        end
    endtask

    task automatic test_count_wrap();
        logic [1:0] want_c2 [4];
        want_c2 = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("a", 1'b1);
            step("1", 1'b1);
            step(" ", 1'b1);
            n_checks++;
            if ({cntc, lastc} !== {want_c2[i], 4'd2}) begin
                n_fail++;
                $display("FAIL wrap_c2_%0d got cnt=%0d last=%0d want %0d 2", i, cntc, lastc, want_c2[i]);
            end
            n_checks++;
            if (cnt8 !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL count_m8_%0d got cnt=%0d want %0d", i, cnt8, i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(" ", 1'b1);
        end
        n_checks++;
        if ({out8, err8, len8, cnt8} !== 14'd0) begin
            n_fail++;
            $display("FAIL b2b_idle got out=%0b err=%0b len=%0d cnt=%0d want all 0", out8, err8, len8, cnt8);
        end
        step("z", 1'b1);
        step("7", 1'b1);
        step("/", 1'b1);
        step("/", 1'b1);
        step(8'h00, 1'b1);
        n_checks++;
        if ({cnt8, last8, len8} !== {8'd1, 4'd2, 4'd0}) begin
            n_fail++;
            $display("FAIL b2b_count got cnt=%0d last=%0d len=%0d want 1 2 0", cnt8, last8, len8);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step("Q", 1'b1);
        end
        n_checks++;
        if ({err8, len8} !== {1'b1, 4'd15}) begin
            n_fail++;
            $display("FAIL len_sat got err=%0b len=%0d want 1 15", err8, len8);
        end
        step("-", 1'b1);
        n_checks++;
        if ({err8, len8, last8, cnt8} !== 17'd0) begin
            n_fail++;
            $display("FAIL sat_exit got err=%0b len=%0d last=%0d cnt=%0d want all 0",
                     err8, len8, last8, cnt8);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        valid    = 1'b0;
        char     = 8'h00;
        test_reset();
        test_max_len();
        test_fail_path();
        test_underscore();
        test_valid_hold();
        test_mid_reset();
        test_count_wrap();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
